// File: rtl/demux_lane_deserializer.sv
// demux_lane_deserializer
// Reassembles the two lane bit streams coming out of a 1-bit demux into
// WIDTH-bit words, LSB first. Each lane has a shift register, a bit counter, a
// one-word holding register with a valid/ready handshake, and a sticky overflow
// flag.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   bit_valid, sel, y0, y1 : one bit per strobe; sel picks the lane (y1 if sel=1, else y0)
//   out0_data/valid/ready  : lane 0 word output handshake
//   out1_data/valid/ready  : lane 1 word output handshake
//   ovf0, ovf1             : sticky flags, set when a lane completes a word while its holding register is full
module demux_lane_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             sel,
  input  logic             y0,
  input  logic             y1,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             ovf0,
  output logic             ovf1
);

  localparam int unsigned LANES = 2;
  localparam int unsigned CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [LANES-1:0][WIDTH-1:0] sr_q;
  logic [LANES-1:0][CW-1:0]    cnt_q;
  logic [LANES-1:0][WIDTH-1:0] out_data_q;
  logic [LANES-1:0]            out_valid_q;
  logic [LANES-1:0]            ovf_q;

  logic                        bit_c;
  logic [LANES-1:0]            ready_c;
  logic [LANES-1:0]            accept_c;
  logic [LANES-1:0]            complete_c;
  logic [LANES-1:0]            free_c;
  logic [LANES-1:0][WIDTH-1:0] word_c;

  // Per-lane decode of the incoming bit and the holding-register state
  always_comb begin
    bit_c   = sel ? y1 : y0;
    ready_c = {out1_ready, out0_ready};
    for (int l = 0; l < int'(LANES); l++) begin
      accept_c[l]   = bit_valid && (sel == (l == 1));
      word_c[l]     = {bit_c, sr_q[l][WIDTH-1:1]};
      complete_c[l] = accept_c[l] && (cnt_q[l] == CNT_LAST);
      // Free if empty or draining on this very edge
      free_c[l]     = !out_valid_q[l] || ready_c[l];
    end
  end

  // Lane state: assembly, holding register, overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      ovf_q       <= '0;
    end else begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (accept_c[l]) begin
          sr_q[l]  <= word_c[l];
          cnt_q[l] <= complete_c[l] ? '0 : cnt_q[l] + CW'(1);
        end
        if (complete_c[l] && free_c[l]) begin
          out_data_q[l]  <= word_c[l];
          out_valid_q[l] <= 1'b1;
        end else begin
          if (out_valid_q[l] && ready_c[l]) begin
            out_valid_q[l] <= 1'b0;
          end
          // Word completed with the holder occupied: drop it, keep old data
          if (complete_c[l]) begin
            ovf_q[l] <= 1'b1;
          end
        end
      end
    end
  end

  assign out0_data  = out_data_q[0];
  assign out0_valid = out_valid_q[0];
  assign out1_data  = out_data_q[1];
  assign out1_valid = out_valid_q[1];
  assign ovf0       = ovf_q[0];
  assign ovf1       = ovf_q[1];

endmodule
